// File: rtl/muladd_pkg.sv
// Shared types and defaults for the muladd arbiter slice.
package muladd_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int LAT_DEF   = 2;
   localparam int NREQ_MAX  = 8;

   typedef logic [$clog2(NREQ_MAX)-1:0] req_id_t;

   typedef struct packed {
      logic    valid;
      req_id_t id;
   } tag_t;

endpackage

// File: rtl/muladd_arbiter_rr_arbiter.sv
// Combinational rotate-priority encoder: grants the first requester strictly
// after ptr, wrapping.
module rr_arbiter
   import muladd_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0] req,
   input  req_id_t      ptr,
   output logic [N-1:0] grant,
   output req_id_t      grant_id,
   output logic         any
);

   // Scan offsets 1..N from the pointer; the first requesting index wins.
   always_comb begin
      grant    = '0;
      grant_id = '0;
      any      = 1'b0;
      for (int k = 1; k <= N; k++) begin
         for (int i = 0; i < N; i++) begin
            if (!any && req[i] && (((int'(ptr) + k) % N) == i)) begin
               grant[i] = 1'b1;
               grant_id = req_id_t'(i);
               any      = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/muladd_arbiter.sv
// Round-robin front end sharing one pipelined muladd among NREQ requesters;
// a tag pipeline matched to the muladd latency routes results back.
module muladd_arbiter
   import muladd_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = WIDTH_DEF,
   parameter int LAT   = LAT_DEF
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ*WIDTH-1:0] req_c,
   input  logic [NREQ-1:0]       cfg_mask,
   output logic [NREQ-1:0]       rsp_valid,
   output logic [WIDTH-1:0]      rsp_y,
   output logic [WIDTH-1:0]      mad_a,
   output logic [WIDTH-1:0]      mad_b,
   output logic [WIDTH-1:0]      mad_c,
   output logic                  mad_en,
   input  logic [WIDTH-1:0]      mad_y,
   output logic                  busy,
   output logic [15:0]           grant_count
);

   logic [NREQ-1:0]  elig;
   logic [NREQ-1:0]  grant;
   req_id_t          grant_id;
   req_id_t          rr_ptr;
   logic             any;
   logic             issue;
   logic [WIDTH-1:0] hold_a, hold_b, hold_c;
   tag_t             tag_p [LAT];
   tag_t             tag_last;

   assign elig = req_valid & cfg_mask;

   rr_arbiter #(.N(NREQ)) u_rr (
      .req      (elig),
      .ptr      (rr_ptr),
      .grant    (grant),
      .grant_id (grant_id),
      .any      (any)
   );

   // A grant seen during reset is not an accepted operation.
   assign issue     = any & ~reset;
   assign req_ready = reset ? '0 : grant;

   // Operand mux: granted requester's slices on issue, last issued values otherwise.
   always_comb begin
      mad_a = hold_a;
      mad_b = hold_b;
      mad_c = hold_c;
      if (issue) begin
         for (int i = 0; i < NREQ; i++) begin
            if (grant_id == req_id_t'(i)) begin
               mad_a = req_a[i*WIDTH +: WIDTH];
               mad_b = req_b[i*WIDTH +: WIDTH];
               mad_c = req_c[i*WIDTH +: WIDTH];
            end
         end
      end
   end

   // Busy while any tag stage carries a live operation.
   always_comb begin
      busy = 1'b0;
      for (int k = 0; k < LAT; k++) begin
         busy = busy | tag_p[k].valid;
      end
   end

   assign mad_en = issue | busy;

   // Pointer, operand hold, grant counter and tag shift register.
   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr      <= req_id_t'(NREQ - 1);
         grant_count <= '0;
         hold_a      <= '0;
         hold_b      <= '0;
         hold_c      <= '0;
         for (int k = 0; k < LAT; k++) begin
            tag_p[k] <= '0;
         end
      end else begin
         if (issue) begin
            rr_ptr <= grant_id;
            hold_a <= mad_a;
            hold_b <= mad_b;
            hold_c <= mad_c;
            if (grant_count != 16'hFFFF) begin
               grant_count <= grant_count + 16'd1;
            end
         end
         // stage 0: tag enters alongside the muladd sampling its operands
         if (mad_en) begin
            tag_p[0] <= '{valid: issue, id: grant_id};
            // stages 1..LAT-1: tag advances in lockstep with the muladd pipe
            for (int k = 1; k < LAT; k++) begin
               tag_p[k] <= tag_p[k-1];
            end
         end
      end
   end

   assign tag_last = tag_p[LAT-1];

   // Final stage steers mad_y to its owner as a single-cycle strobe.
   always_comb begin
      rsp_valid = '0;
      rsp_y     = '0;
      if (tag_last.valid && !reset) begin
         rsp_y = mad_y;
         for (int i = 0; i < NREQ; i++) begin
            if (tag_last.id == req_id_t'(i)) begin
               rsp_valid[i] = 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_muladd_arbiter.sv
// Directed bench for muladd_arbiter with a behavioural 2-stage muladd.
module tb_muladd_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int LAT   = 2;

   logic                  clock = 1'b0;
   logic                  reset;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a, req_b, req_c;
   logic [NREQ-1:0]       cfg_mask;
   logic [NREQ-1:0]       rsp_valid;
   logic [WIDTH-1:0]      rsp_y;
   logic [WIDTH-1:0]      mad_a, mad_b, mad_c;
   logic                  mad_en;
   logic [WIDTH-1:0]      mad_y;
   logic                  busy;
   logic [15:0]           grant_count;

   int nvec = 0;
   int nerr = 0;

   muladd_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(LAT)) dut (
      .clock       (clock),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_c       (req_c),
      .cfg_mask    (cfg_mask),
      .rsp_valid   (rsp_valid),
      .rsp_y       (rsp_y),
      .mad_a       (mad_a),
      .mad_b       (mad_b),
      .mad_c       (mad_c),
      .mad_en      (mad_en),
      .mad_y       (mad_y),
      .busy        (busy),
      .grant_count (grant_count)
   );

   always #5 clock = ~clock;

   // External muladd: two registered stages advancing on mad_en.
   logic [WIDTH-1:0] mul_p1, mul_p2;
   always_ff @(posedge clock) begin
      if (mad_en) begin
         mul_p1 <= mad_a * mad_b + mad_c;
         mul_p2 <= mul_p1;
      end
   end
   assign mad_y = mul_p2;

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      req_a[i*WIDTH +: WIDTH] = a;
      req_b[i*WIDTH +: WIDTH] = b;
      req_c[i*WIDTH +: WIDTH] = c;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      req_valid = '0;
      step();
      reset = 1'b0;
   endtask

   task automatic load_default_ops();
      for (int i = 0; i < NREQ; i++) set_op(i, 8'(i + 1), 8'd2, 8'(i));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int gexp [8];
      int rexp [8];
      int yexp [8];

      reset     = 1'b1;
      req_valid = '0;
      cfg_mask  = 4'b1111;
      req_a     = '0;
      req_b     = '0;
      req_c     = '0;
      step();
      step();
      reset = 1'b0;
      #1;
      // reset state
      check_vec("rst_ready", req_ready, 0);
      check_vec("rst_rsp_valid", rsp_valid, 0);
      check_vec("rst_rsp_y", rsp_y, 0);
      check_vec("rst_mad_a", mad_a, 0);
      check_vec("rst_mad_b", mad_b, 0);
      check_vec("rst_mad_c", mad_c, 0);
      check_vec("rst_mad_en", mad_en, 0);
      check_vec("rst_busy", busy, 0);
      check_vec("rst_count", grant_count, 0);

      // single requester: 4*2+3 = 11
      set_op(0, 8'd4, 8'd2, 8'd3);
      req_valid = 4'b0001;
      #1;
      check_vec("t1_ready", req_ready, 4'b0001);
      check_vec("t1_mad_a", mad_a, 4);
      check_vec("t1_mad_en", mad_en, 1);
      step();
      req_valid = '0;
      #1;
      check_vec("t1_busy_c1", busy, 1);
      check_vec("t1_rsp_c1", rsp_valid, 0);
      check_vec("t1_count", grant_count, 1);
      step();
      #1;
      check_vec("t1_rsp_c2", rsp_valid, 4'b0001);
      check_vec("t1_y", rsp_y, 11);
      check_vec("t1_busy_c2", busy, 1);
      step();
      #1;
      check_vec("t1_busy_c3", busy, 0);
      check_vec("t1_rsp_c3", rsp_valid, 0);

      // all four continuously valid: grants 0,1,2,3,..., y = 3i+2
      do_reset();
      load_default_ops();
      req_valid = 4'b1111;
      for (int k = 0; k < 10; k++) begin
         if (k == 8) req_valid = '0;
         #1;
         check_vec($sformatf("t2_ready_%0d", k), req_ready, (k < 8) ? (1 << (k % 4)) : 0);
         if (k >= 2) begin
            check_vec($sformatf("t2_rsp_%0d", k), rsp_valid, 1 << ((k - 2) % 4));
            check_vec($sformatf("t2_y_%0d", k), rsp_y, 3 * ((k - 2) % 4) + 2);
         end else begin
            check_vec($sformatf("t2_rsp_%0d", k), rsp_valid, 0);
         end
         step();
      end
      #1;
      check_vec("t2_busy", busy, 0);
      check_vec("t2_count", grant_count, 8);

      // wrap-around: 16*16+5 -> 5, 255*255+0 -> 1
      do_reset();
      set_op(0, 8'd16, 8'd16, 8'd5);
      set_op(1, 8'd255, 8'd255, 8'd0);
      req_valid = 4'b0001;
      #1;
      check_vec("t3_ready0", req_ready, 4'b0001);
      step();
      req_valid = 4'b0010;
      #1;
      check_vec("t3_ready1", req_ready, 4'b0010);
      step();
      req_valid = '0;
      #1;
      check_vec("t3_rsp0", rsp_valid, 4'b0001);
      check_vec("t3_y0", rsp_y, 5);
      step();
      #1;
      check_vec("t3_rsp1", rsp_valid, 4'b0010);
      check_vec("t3_y1", rsp_y, 1);
      step();

      // mask 1010: grants alternate 1,3; bit 1 cleared while op1 is in flight
      do_reset();
      load_default_ops();
      gexp = '{2, 8, 2, 8, 8, 0, 0, 0};
      rexp = '{0, 0, 2, 8, 2, 8, 8, 0};
      yexp = '{0, 0, 5, 11, 5, 11, 11, 0};
      for (int k = 0; k < 8; k++) begin
         cfg_mask  = (k < 4) ? 4'b1010 : 4'b1000;
         req_valid = (k < 5) ? 4'b1111 : 4'b0000;
         #1;
         check_vec($sformatf("t4_ready_%0d", k), req_ready, gexp[k]);
         check_vec($sformatf("t4_rsp_%0d", k), rsp_valid, rexp[k]);
         if (rexp[k] != 0) check_vec($sformatf("t4_y_%0d", k), rsp_y, yexp[k]);
         step();
      end
      cfg_mask = 4'b1111;

      // reset mid-flight discards both ops
      do_reset();
      load_default_ops();
      req_valid = 4'b0011;
      #1;
      check_vec("t5_ready0", req_ready, 4'b0001);
      step();
      #1;
      check_vec("t5_ready1", req_ready, 4'b0010);
      step();
      reset     = 1'b1;
      req_valid = '0;
      #1;
      check_vec("t5_rsp_in_reset", rsp_valid, 0);
      step();
      reset = 1'b0;
      #1;
      check_vec("t5_rsp_after", rsp_valid, 0);
      check_vec("t5_busy", busy, 0);
      check_vec("t5_count", grant_count, 0);
      step();
      req_valid = 4'b1111;
      #1;
      check_vec("t5_first_grant", req_ready, 4'b0001);
      check_vec("t5_mad_a", mad_a, 1);
      step();
      req_valid = '0;
      step();
      #1;
      check_vec("t5_rsp", rsp_valid, 4'b0001);
      check_vec("t5_y", rsp_y, 2);
      step();

      // idle: operands hold last issue (a=1,b=2,c=0), nothing moves
      for (int k = 0; k < 10; k++) begin
         #1;
         check_vec($sformatf("t6_en_%0d", k), mad_en, 0);
         check_vec($sformatf("t6_rsp_%0d", k), rsp_valid, 0);
         check_vec($sformatf("t6_a_%0d", k), mad_a, 1);
         check_vec($sformatf("t6_b_%0d", k), mad_b, 2);
         check_vec($sformatf("t6_c_%0d", k), mad_c, 0);
         step();
      end
      check_vec("t6_count", grant_count, 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
